// File: rtl/dmem_stall.sv
// dmem_stall: wait-state data memory with a req/ready handshake, byte write strobes and
// out-of-range error reporting. One transaction in flight at a time.
module dmem_stall #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 64,
  parameter int unsigned WAIT   = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                req,
  input  logic                we,
  input  logic [DATA_W/8-1:0] be,
  input  logic [31:0]         addr,
  input  logic [DATA_W-1:0]   wdata,
  output logic [DATA_W-1:0]   rdata,
  output logic                ready,
  output logic                err,
  output logic                busy
);

  localparam int unsigned NB   = DATA_W / 8;
  localparam int unsigned OFF  = $clog2(NB);
  localparam int unsigned IDXW = $clog2(DEPTH);
  // One bit wider than the address so the byte limit itself never overflows.
  localparam logic [32:0] LIMIT = 33'(DEPTH * NB);

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e              state_q;
  logic [3:0]          cnt_q;
  logic                we_q;
  logic [NB-1:0]       be_q;
  logic [31:0]         addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [DATA_W-1:0]   mem [DEPTH];

  logic                in_range;
  logic [IDXW-1:0]     idx;
  logic                access;

  assign in_range = ({1'b0, addr_q} < LIMIT);
  assign idx      = addr_q[OFF +: IDXW];
  // The access edge: last BUSY cycle once the wait counter has drained.
  assign access   = (state_q == StBusy) && (cnt_q == 4'd0);
  assign busy     = (state_q == StBusy);

  // Handshake FSM with registered ready/err/rdata; captures the request at accept.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= 4'd0;
      we_q    <= 1'b0;
      be_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      ready   <= 1'b0;
      err     <= 1'b0;
      rdata   <= '0;
    end else begin
      ready <= 1'b0;
      err   <= 1'b0;
      case (state_q)
        StIdle, StDone: begin
          if (req) begin
            we_q    <= we;
            be_q    <= be;
            addr_q  <= addr;
            wdata_q <= wdata;
            cnt_q   <= 4'(WAIT);
            state_q <= StBusy;
          end else begin
            state_q <= StIdle;
          end
        end
        StBusy: begin
          if (cnt_q != 4'd0) begin
            cnt_q <= cnt_q - 4'd1;
          end else begin
            state_q <= StDone;
            ready   <= 1'b1;
            err     <= ~in_range;
            // Writes and faulting accesses present zero in the ready cycle.
            rdata   <= (!we_q && in_range) ? mem[idx] : '0;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Byte-lane write at the access edge; storage itself is never reset.
  always_ff @(posedge clk) begin
    if (!reset && access && we_q && in_range) begin
      for (int i = 0; i < int'(NB); i++) begin
        if (be_q[i]) begin
          mem[idx][8*i +: 8] <= wdata_q[8*i +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_dmem_stall.sv
// Bench for dmem_stall: three instances (WAIT=2, 0, 5) share stimulus, selected by sel.
module tb_dmem_stall;

  logic        clk = 1'b0;
  logic        reset;
  logic        req;
  logic        we;
  logic [3:0]  be;
  logic [31:0] addr;
  logic [31:0] wdata;
  int          sel;

  logic        req0, req1, req2;
  logic [31:0] rd0, rd1, rd2;
  logic        rdy0, rdy1, rdy2;
  logic        err0, err1, err2;
  logic        bsy0, bsy1, bsy2;

  logic [31:0] rdata_m;
  logic        ready_m, err_m, busy_m;

  int total = 0;
  int bad   = 0;

  // Byte-addressed reference memory per instance, with a known-byte map.
  byte unsigned mb [3][256];
  bit           kn [3][256];

  always #5 clk = ~clk;

  assign req0 = req && (sel == 0);
  assign req1 = req && (sel == 1);
  assign req2 = req && (sel == 2);

  always_comb begin
    case (sel)
      1: begin rdata_m = rd1; ready_m = rdy1; err_m = err1; busy_m = bsy1; end
      2: begin rdata_m = rd2; ready_m = rdy2; err_m = err2; busy_m = bsy2; end
      default: begin rdata_m = rd0; ready_m = rdy0; err_m = err0; busy_m = bsy0; end
    endcase
  end

  dmem_stall #(.DATA_W(32), .DEPTH(64), .WAIT(2)) u_w2 (
    .clk(clk), .reset(reset), .req(req0), .we(we), .be(be), .addr(addr), .wdata(wdata),
    .rdata(rd0), .ready(rdy0), .err(err0), .busy(bsy0)
  );
  dmem_stall #(.DATA_W(32), .DEPTH(64), .WAIT(0)) u_w0 (
    .clk(clk), .reset(reset), .req(req1), .we(we), .be(be), .addr(addr), .wdata(wdata),
    .rdata(rd1), .ready(rdy1), .err(err1), .busy(bsy1)
  );
  dmem_stall #(.DATA_W(32), .DEPTH(64), .WAIT(5)) u_w5 (
    .clk(clk), .reset(reset), .req(req2), .we(we), .be(be), .addr(addr), .wdata(wdata),
    .rdata(rd2), .ready(rdy2), .err(err2), .busy(bsy2)
  );

  function automatic int wait_of(input int d);
    return (d == 1) ? 0 : (d == 2) ? 5 : 2;
  endfunction

  // Reference: 256-byte memory; anything at or above 256 faults and changes nothing.
  task automatic model_txn(input int d, input logic w, input logic [3:0] b,
                           input logic [31:0] a, input logic [31:0] wd,
                           output logic [31:0] er, output logic ee, output logic [31:0] mk);
    er = '0;
    ee = 1'b0;
    mk = '1;
    if (a >= 32'd256) begin
      ee = 1'b1;
    end else begin
      int base;
      base = int'(a) & ~3;
      for (int i = 0; i < 4; i++) begin
        if (w) begin
          if (b[i]) begin
            mb[d][base+i] = wd[8*i +: 8];
            kn[d][base+i] = 1'b1;
          end
        end else begin
          er[8*i +: 8] = mb[d][base+i];
          if (!kn[d][base+i]) mk[8*i +: 8] = 8'h00;
        end
      end
    end
  endtask

  // Drive one transaction on the selected instance and observe its completion.
  task automatic issue(input logic w, input logic [3:0] b, input logic [31:0] a,
                       input logic [31:0] wd, input bit noise,
                       output logic [31:0] rd, output logic e, output int lat,
                       output bit busy_ok, output logic after_rdy);
    @(negedge clk);
    req = 1'b1; we = w; be = b; addr = a; wdata = wd;
    @(posedge clk); #1;
    busy_ok = (busy_m === 1'b1);
    req = 1'b0; we = 1'($urandom); be = 4'($urandom); addr = $urandom; wdata = $urandom;
    lat = -1; rd = 'x; e = 1'bx;
    for (int k = 1; k <= 40; k++) begin
      if (noise) begin
        req = 1'($urandom); we = 1'($urandom); be = 4'($urandom);
        addr = $urandom; wdata = $urandom;
      end
      @(posedge clk); #1;
      if (ready_m === 1'b1) begin
        lat = k; rd = rdata_m; e = err_m;
        if (busy_m !== 1'b0) busy_ok = 1'b0;
        break;
      end
      if (busy_m !== 1'b1) busy_ok = 1'b0;
    end
    req = 1'b0;
    @(posedge clk); #1;
    after_rdy = ready_m;
  endtask

  task automatic test_reset();
    reset = 1'b1; req = 1'b0; we = 1'b0; be = '0; addr = '0; wdata = '0;
    repeat (3) @(posedge clk);
    #1;
    for (int s = 0; s < 3; s++) begin
      sel = s;
      #1;
      total++; if (ready_m !== 1'b0) begin bad++; $display("FAIL rst_ready[%0d]: got %b want 0", s, ready_m); end
      total++; if (err_m !== 1'b0) begin bad++; $display("FAIL rst_err[%0d]: got %b want 0", s, err_m); end
      total++; if (busy_m !== 1'b0) begin bad++; $display("FAIL rst_busy[%0d]: got %b want 0", s, busy_m); end
      total++; if (rdata_m !== 32'h0) begin bad++; $display("FAIL rst_rdata[%0d]: got %h want 0", s, rdata_m); end
    end
    @(negedge clk);
    reset = 1'b0;
    sel = 0;
  endtask

  task automatic test_write_read();
    logic [31:0] rd, er, mk; logic e, ee, ar; int lat; bit bok;
    sel = 0;
    issue(1'b1, 4'hF, 32'h10, 32'hDEADBEEF, 1'b0, rd, e, lat, bok, ar);
    model_txn(0, 1'b1, 4'hF, 32'h10, 32'hDEADBEEF, er, ee, mk);
    total++; if (lat != 3) begin bad++; $display("FAIL wr_latency: got %0d want 3", lat); end
    total++; if (e !== 1'b0) begin bad++; $display("FAIL wr_err: got %b want 0", e); end
    total++; if (rd !== 32'h0) begin bad++; $display("FAIL wr_rdata: got %h want 0", rd); end
    total++; if (bok !== 1'b1) begin bad++; $display("FAIL wr_busy: got %b want 1", bok); end
    total++; if (ar !== 1'b0) begin bad++; $display("FAIL wr_single_pulse: got %b want 0", ar); end
    issue(1'b0, 4'h0, 32'h10, 32'h0, 1'b0, rd, e, lat, bok, ar);
    model_txn(0, 1'b0, 4'h0, 32'h10, 32'h0, er, ee, mk);
    total++; if (lat != 3) begin bad++; $display("FAIL rd_latency: got %0d want 3", lat); end
    total++; if (rd !== 32'hDEADBEEF) begin bad++; $display("FAIL rd_data: got %h want deadbeef", rd); end
    total++; if (e !== 1'b0) begin bad++; $display("FAIL rd_err: got %b want 0", e); end
    total++; if (ar !== 1'b0) begin bad++; $display("FAIL rd_single_pulse: got %b want 0", ar); end
  endtask

  task automatic test_byte_strobes();
    logic [31:0] rd, er, mk; logic e, ee, ar; int lat; bit bok;
    sel = 0;
    issue(1'b1, 4'hF, 32'h8, 32'h11223344, 1'b0, rd, e, lat, bok, ar);
    model_txn(0, 1'b1, 4'hF, 32'h8, 32'h11223344, er, ee, mk);
    issue(1'b1, 4'b0101, 32'h8, 32'hAABBCCDD, 1'b0, rd, e, lat, bok, ar);
    model_txn(0, 1'b1, 4'b0101, 32'h8, 32'hAABBCCDD, er, ee, mk);
    issue(1'b0, 4'h0, 32'h8, 32'h0, 1'b0, rd, e, lat, bok, ar);
    model_txn(0, 1'b0, 4'h0, 32'h8, 32'h0, er, ee, mk);
    total++; if (rd !== 32'h11BB33DD) begin bad++; $display("FAIL strobe_data: got %h want 11bb33dd", rd); end
    total++; if (rd !== er) begin bad++; $display("FAIL strobe_model: got %h want %h", rd, er); end
  endtask

  task automatic test_out_of_range();
    logic [31:0] rd, er, mk, x; logic e, ee, ar; int lat; bit bok;
    sel = 0;
    x = $urandom;
    issue(1'b1, 4'hF, 32'h0, x, 1'b0, rd, e, lat, bok, ar);
    model_txn(0, 1'b1, 4'hF, 32'h0, x, er, ee, mk);
    // 0x100 aliases word 0 in the index bits, so a leaked write would corrupt it.
    issue(1'b1, 4'hF, 32'h100, ~x, 1'b0, rd, e, lat, bok, ar);
    total++; if (e !== 1'b1) begin bad++; $display("FAIL oor_wr_err: got %b want 1", e); end
    total++; if (lat != 3) begin bad++; $display("FAIL oor_wr_latency: got %0d want 3", lat); end
    rd = $urandom;
    issue(1'b0, 4'h0, 32'h100, 32'h0, 1'b0, rd, e, lat, bok, ar);
    total++; if (e !== 1'b1) begin bad++; $display("FAIL oor_rd_err: got %b want 1", e); end
    total++; if (rd !== 32'h0) begin bad++; $display("FAIL oor_rd_data: got %h want 0", rd); end
    issue(1'b0, 4'h0, 32'hFFFF_FFFC, 32'h0, 1'b0, rd, e, lat, bok, ar);
    total++; if (e !== 1'b1) begin bad++; $display("FAIL oor_top_err: got %b want 1", e); end
    // Zero-strobe write completes normally and leaves the word alone.
    issue(1'b1, 4'h0, 32'h0, ~x, 1'b0, rd, e, lat, bok, ar);
    total++; if (lat != 3 || e !== 1'b0) begin bad++; $display("FAIL be0_complete: got lat=%0d err=%b want lat=3 err=0", lat, e); end
    issue(1'b0, 4'h0, 32'h0, 32'h0, 1'b0, rd, e, lat, bok, ar);
    total++; if (rd !== x) begin bad++; $display("FAIL oor_mem_kept: got %h want %h", rd, x); end
    total++; if (e !== 1'b0) begin bad++; $display("FAIL in_range_err: got %b want 0", e); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] vals [4];
    logic [31:0] rd, er, mk; logic e, ee, ar; int lat; bit bok;
    int rc [4];
    int n;
    sel = 1;
    for (int i = 0; i < 4; i++) vals[i] = $urandom;
    n = 0;
    @(negedge clk);
    req = 1'b1; we = 1'b1; be = 4'hF; addr = 32'h0; wdata = vals[0];
    for (int c = 1; c <= 40 && n < 4; c++) begin
      @(posedge clk); #1;
      if (ready_m === 1'b1) begin
        rc[n] = c;
        n++;
        if (n < 4) begin addr = 32'(4 * n); wdata = vals[n]; end
        else req = 1'b0;
      end
    end
    req = 1'b0;
    total++; if (n != 4) begin bad++; $display("FAIL b2b_count: got %0d want 4", n); end
    if (n == 4) begin
      total++; if (rc[0] != 2) begin bad++; $display("FAIL b2b_first: got %0d want 2", rc[0]); end
      for (int i = 1; i < 4; i++) begin
        total++;
        if (rc[i] - rc[i-1] != wait_of(1) + 2) begin
          bad++; $display("FAIL b2b_spacing[%0d]: got %0d want %0d", i, rc[i] - rc[i-1], wait_of(1) + 2);
        end
      end
    end
    for (int i = 0; i < 4; i++) model_txn(1, 1'b1, 4'hF, 32'(4 * i), vals[i], er, ee, mk);
    for (int i = 0; i < 4; i++) begin
      issue(1'b0, 4'h0, 32'(4 * i), 32'h0, 1'b0, rd, e, lat, bok, ar);
      model_txn(1, 1'b0, 4'h0, 32'(4 * i), 32'h0, er, ee, mk);
      total++; if (rd !== er) begin bad++; $display("FAIL b2b_read[%0d]: got %h want %h", i, rd, er); end
      total++; if (lat != 1) begin bad++; $display("FAIL b2b_rd_latency[%0d]: got %0d want 1", i, lat); end
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd, er, mk, v; logic e, ee, ar; int lat; bit bok; bit seen;
    sel = 2;
    v = $urandom | 32'h1;
    issue(1'b1, 4'hF, 32'h20, v, 1'b0, rd, e, lat, bok, ar);
    model_txn(2, 1'b1, 4'hF, 32'h20, v, er, ee, mk);
    issue(1'b0, 4'h0, 32'h20, 32'h0, 1'b0, rd, e, lat, bok, ar);
    model_txn(2, 1'b0, 4'h0, 32'h20, 32'h0, er, ee, mk);
    total++; if (lat != 6) begin bad++; $display("FAIL w5_latency: got %0d want 6", lat); end
    total++; if (rd !== v) begin bad++; $display("FAIL w5_read: got %h want %h", rd, v); end
    @(negedge clk);
    req = 1'b1; we = 1'b1; be = 4'hF; addr = 32'h20; wdata = 32'h5A5A5A5A;
    @(posedge clk); #1;
    req = 1'b0;
    seen = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
      if (ready_m === 1'b1) seen = 1'b1;
    end
    reset = 1'b1;
    @(posedge clk); #1;
    total++; if (ready_m !== 1'b0) begin bad++; $display("FAIL mid_rst_ready: got %b want 0", ready_m); end
    total++; if (err_m !== 1'b0) begin bad++; $display("FAIL mid_rst_err: got %b want 0", err_m); end
    total++; if (busy_m !== 1'b0) begin bad++; $display("FAIL mid_rst_busy: got %b want 0", busy_m); end
    total++; if (rdata_m !== 32'h0) begin bad++; $display("FAIL mid_rst_rdata: got %h want 0", rdata_m); end
    reset = 1'b0;
    repeat (10) begin
      @(posedge clk); #1;
      if (ready_m === 1'b1) seen = 1'b1;
    end
    total++; if (seen) begin bad++; $display("FAIL mid_rst_no_ready: got 1 want 0"); end
    issue(1'b0, 4'h0, 32'h20, 32'h0, 1'b0, rd, e, lat, bok, ar);
    model_txn(2, 1'b0, 4'h0, 32'h20, 32'h0, er, ee, mk);
    total++; if (rd !== er) begin bad++; $display("FAIL mid_rst_mem: got %h want %h", rd, er); end
  endtask

  task automatic test_ignored();
    logic [31:0] rd, er, mk, d; logic e, ee, ar; int lat; bit bok;
    sel = 0;
    d = $urandom;
    issue(1'b1, 4'hF, 32'h30, d, 1'b1, rd, e, lat, bok, ar);
    model_txn(0, 1'b1, 4'hF, 32'h30, d, er, ee, mk);
    total++; if (lat != 3 || e !== 1'b0) begin bad++; $display("FAIL ign_wr: got lat=%0d err=%b want lat=3 err=0", lat, e); end
    total++; if (ar !== 1'b0) begin bad++; $display("FAIL ign_extra_ready: got %b want 0", ar); end
    issue(1'b0, 4'h0, 32'h30, 32'h0, 1'b1, rd, e, lat, bok, ar);
    model_txn(0, 1'b0, 4'h0, 32'h30, 32'h0, er, ee, mk);
    total++; if (rd !== d) begin bad++; $display("FAIL ign_rd: got %h want %h", rd, d); end
    total++; if (bok !== 1'b1) begin bad++; $display("FAIL ign_busy: got %b want 1", bok); end
  endtask

  task automatic test_random();
    logic [31:0] rd, er, mk, a, wd; logic e, ee, ar, w; logic [3:0] b; int lat; bit bok;
    sel = 0;
    for (int t = 0; t < 40; t++) begin
      w  = 1'($urandom);
      b  = 4'($urandom);
      a  = 32'($urandom_range(0, 32'h13F));
      wd = $urandom;
      issue(w, b, a, wd, 1'($urandom), rd, e, lat, bok, ar);
      model_txn(0, w, b, a, wd, er, ee, mk);
      total++;
      if (lat != wait_of(0) + 1 || e !== ee || (rd & mk) !== (er & mk) || ar !== 1'b0) begin
        bad++;
        $display("FAIL rand[%0d] a=%h we=%b: got lat=%0d err=%b rd=%h want lat=%0d err=%b rd=%h (mask %h)",
                 t, a, w, lat, e, rd, wait_of(0) + 1, ee, er, mk);
      end
    end
  endtask

  initial begin
    sel = 0;
    test_reset();
    test_write_read();
    test_byte_strobes();
    test_out_of_range();
    test_back_to_back();
    test_reset_mid();
    test_ignored();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/dmem_stall.md
# dmem_stall

Parametrised, wait-state data memory for the ARM core. It replaces the zero-latency `dmem` with a synchronous request/ready slave of configurable word width, depth and access latency, and adds per-byte write strobes and out-of-range error reporting. The core issues one transaction at a time and stalls until `ready`. It sits between the core's ALUResult/WriteData/MemWrite paths and its ReadData input.

## Interface
- `DATA_W`, 32: word width in bits; multiple of 8, at least 16.
- `DEPTH`, 64: number of words; power of two, at least 2.
- `WAIT`, 2: extra wait cycles per access; legal range 0..15.
- `clk`  in  1: single clock, rising-edge.
- `reset`  in  1: synchronous, active-high.
- `req`  in  1: transaction request; sampled only in IDLE and DONE.
- `we`  in  1: 1 = write, 0 = read; captured at accept.
- `be`  in  DATA_W/8: byte write strobes; captured at accept; ignored on reads.
- `addr`  in  32: byte address; captured at accept.
- `wdata`  in  DATA_W: write data; captured at accept.
- `rdata`  out  DATA_W: registered read data; valid while `ready` is 1.
- `ready`  out  1: one-cycle completion pulse.
- `err`  out  1: high with `ready` when the captured address is out of range.
- `busy`  out  1: high while in BUSY.

## Operation
- OFF = log2(DATA_W/8) byte-offset bits. Word index = addr[OFF+log2(DEPTH)-1 : OFF]. Low OFF bits are ignored; there is no misalignment fault.
- Out of range: addr ≥ DEPTH·DATA_W/8. For such an access:
  - no memory write;
  - `rdata` = 0;
  - `err` = 1 during the `ready` cycle.
- FSM has three states: IDLE, BUSY, DONE.
- IDLE:
  - If `req` = 1, accept: capture we/be/addr/wdata, load cnt = WAIT, go to BUSY.
  - Otherwise stay in IDLE.
- BUSY:
  - If cnt ≠ 0: cnt decrements.
  - If cnt = 0, perform the access at this edge and go to DONE:
    - write: each byte lane i with be[i] = 1 is updated from wdata; other lanes are kept;
    - read: `rdata` ← mem[index].
  - `req` is ignored throughout BUSY.
- DONE:
  - `ready` = 1 and `err` is valid.
  - If `req` = 1, accept a new transaction (capture, cnt = WAIT, go to BUSY); this gives back-to-back operation.
  - Otherwise go to IDLE.
- Master rule: the master must lower `req` in the `ready` cycle unless it is issuing the next transaction. A held `req` is treated as a new request.
- Write with be = 0: completes normally (ready pulse), memory unchanged.
- `rdata` keeps its value outside read completions. Writes and error completions drive `rdata` to 0 in the `ready` cycle.
- Memory contents are not reset.
- Reset, including mid-transaction:
  - state = IDLE, cnt = 0;
  - `ready` = 0, `err` = 0, `busy` = 0, `rdata` = 0;
  - a pending write is dropped; memory is untouched.

## Timing
- Let edge E0 be the edge that accepts a request. Then:
  - BUSY is entered at E0;
  - edges E1..E_WAIT decrement cnt;
  - the access happens at edge E_(WAIT+1);
  - `ready` is high for exactly the cycle after E_(WAIT+1).
- Latency from accept edge to `ready` cycle is WAIT+1 edges. WAIT = 0 gives `ready` in the cycle after the first BUSY cycle.
- Sustained throughput with back-to-back requests: one transaction per WAIT+2 cycles.
- `busy` = (state == BUSY). `ready`, `err` and `rdata` are all registered; there are no combinational input-to-output paths.
- Reset dominates every other event on the same edge.

## Test plan
- **Write then read, WAIT=2:**
  - stimulus: write addr 0x10, wdata 0xDEADBEEF, be 4'hF; then read 0x10;
  - each `ready` appears 3 edges after accept;
  - read returns `rdata` = 0xDEADBEEF with `err` = 0.
- **Byte strobes:**
  - stimulus: preload 0x11223344 at 0x8; write 0xAABBCCDD with be = 4'b0101; read back;
  - required: `rdata` = 0x11BB33DD.
- **Out of range, DEPTH=64:**
  - stimulus: write 0x100 then read 0x100;
  - both completions have `err` = 1;
  - read gives `rdata` = 0;
  - a read of 0x0 afterwards shows memory unchanged.
- **Back-to-back, WAIT=0:**
  - stimulus: `req` held high with new addr/wdata each DONE cycle, four writes to 0x0/0x4/0x8/0xC;
  - `ready` pulses every 2 cycles;
  - four reads return the four written values.
- **Reset mid-operation, WAIT=5:**
  - stimulus: write 0x5A5A5A5A to 0x20; assert `reset` at cycle 3 after accept;
  - no `ready` pulse;
  - all outputs are 0 the cycle after reset;
  - a subsequent read of 0x20 returns the pre-existing value.
- **Ignored requests:**
  - stimulus: during BUSY, toggle `req`/addr;
  - required: no effect; the completion reflects the captured transaction only.
